cache_controller: RTL and testbench

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_controller_pkg.sv | 26 ++
 rtl/cache_controller_cache_mem.sv | 67 ++++++
 rtl/cache_controller.sv | 137 +++++++++++++
 tb/tb_cache_controller.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_controller_pkg.sv
// Shared constants, FSM encoding and lookup result type for the 2-way
// write-through data cache.
package cache_controller_pkg;

    localparam int DEF_SETS  = 64;
    localparam int DEF_TAG_W = 10;
    localparam int LINE_W    = 64;
    localparam int WORD_W    = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    typedef struct packed {
        logic              hit;
        logic              hit_way;
        logic              lru_way;
        logic [LINE_W-1:0] hit_line;
    } lookup_t;

    function automatic logic [WORD_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                   input logic sel);
        return sel ? line[LINE_W-1:WORD_W] : line[WORD_W-1:0];
    endfunction

endpackage

// File: rtl/cache_controller_cache_mem.sv
// Tag/valid/data/LRU storage: combinational lookup, synchronous fill,
// invalidate and recency-update ports.
module cache_mem
    import cache_controller_pkg::*;
#(
    parameter int SETS  = DEF_SETS,
    parameter int TAG_W = DEF_TAG_W,
    localparam int IDX_W = $clog2(SETS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  lk_index,
    input  logic [TAG_W-1:0]  lk_tag,
    output lookup_t           lk,
    input  logic              fill_en,
    input  logic              fill_way,
    input  logic [IDX_W-1:0]  fill_index,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [LINE_W-1:0] fill_line,
    input  logic              inval_en,
    input  logic              inval_way,
    input  logic [IDX_W-1:0]  inval_index,
    input  logic              touch_en,
    input  logic              touch_way,
    input  logic [IDX_W-1:0]  touch_index
);

    logic [SETS-1:0][1:0] valid_q;
    logic [SETS-1:0]      lru_q;
    logic [TAG_W-1:0]     tag_q  [SETS][2];
    logic [LINE_W-1:0]    line_q [SETS][2];

    logic hit0, hit1;

    assign hit0 = valid_q[lk_index][0] && (tag_q[lk_index][0] == lk_tag);
    assign hit1 = valid_q[lk_index][1] && (tag_q[lk_index][1] == lk_tag);

    assign lk = '{hit:      hit0 | hit1,
                  hit_way:  hit1,
                  lru_way:  lru_q[lk_index],
                  hit_line: hit1 ? line_q[lk_index][1] : line_q[lk_index][0]};

    // lru points at the least recently used way, so touching a way
    // points it at the other one.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            lru_q   <= '0;
        end else begin
            if (fill_en)
                valid_q[fill_index][fill_way] <= 1'b1;
            if (inval_en)
                valid_q[inval_index][inval_way] <= 1'b0;
            if (touch_en)
                lru_q[touch_index] <= ~touch_way;
        end
    end

    // Tag and line storage carry no reset; a reset cycle must still block a fill.
    always_ff @(posedge clk) begin
        if (fill_en && !rst) begin
            tag_q[fill_index][fill_way]  <= fill_tag;
            line_q[fill_index][fill_way] <= fill_line;
        end
    end

endmodule

// File: rtl/cache_controller.sv
// 2-way set-associative write-through, no-write-allocate cache controller
// sitting between the memory stage and the SRAM controller.
module cache_controller
    import cache_controller_pkg::*;
#(
    parameter int SETS  = DEF_SETS,
    parameter int TAG_W = DEF_TAG_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    output logic        sram_r_en,
    output logic        sram_w_en,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
);

    localparam int IDX_W   = $clog2(SETS);
    localparam int IDX_LSB = 3;
    localparam int TAG_LSB = IDX_LSB + IDX_W;

    logic [1:0]       state, state_d;
    logic             word;
    logic [IDX_W-1:0] index;
    logic [TAG_W-1:0] tag;
    lookup_t          lk;

    logic             fill_en, inval_en, touch_en, touch_way;
    logic [IDX_W-1:0] touch_index;
    logic [IDX_W-1:0] fill_index_q;
    logic [TAG_W-1:0] fill_tag_q;
    logic             fill_way_q;
    logic             unused_addr;

    assign word         = address[2];
    assign index        = address[IDX_LSB +: IDX_W];
    assign tag          = address[TAG_LSB +: TAG_W];
    assign unused_addr  = ^{address[1:0], address[31:TAG_LSB+TAG_W]};
    assign sram_address = address;
    assign sram_wdata   = wdata;

    cache_mem #(.SETS(SETS), .TAG_W(TAG_W)) u_mem (
        .clk         (clk),
        .rst         (rst),
        .lk_index    (index),
        .lk_tag      (tag),
        .lk          (lk),
        .fill_en     (fill_en),
        .fill_way    (fill_way_q),
        .fill_index  (fill_index_q),
        .fill_tag    (fill_tag_q),
        .fill_line   (sram_rdata),
        .inval_en    (inval_en),
        .inval_way   (lk.hit_way),
        .inval_index (index),
        .touch_en    (touch_en),
        .touch_way   (touch_way),
        .touch_index (touch_index)
    );

    always_comb begin
        state_d     = state;
        ready       = 1'b0;
        rdata       = '0;
        sram_r_en   = 1'b0;
        sram_w_en   = 1'b0;
        fill_en     = 1'b0;
        inval_en    = 1'b0;
        touch_en    = 1'b0;
        touch_way   = lk.hit_way;
        touch_index = index;
        case (state)
            ST_IDLE: begin
                // A simultaneous load+store is handled as a store.
                if (mem_w_en) begin
                    inval_en = lk.hit;
                    state_d  = ST_WRITE;
                end else if (mem_r_en) begin
                    if (lk.hit) begin
                        ready    = 1'b1;
                        rdata    = word_sel(lk.hit_line, word);
                        touch_en = 1'b1;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    ready = 1'b1;
                end
            end
            ST_FILL: begin
                sram_r_en = 1'b1;
                if (sram_ready) begin
                    fill_en     = 1'b1;
                    touch_en    = 1'b1;
                    touch_way   = fill_way_q;
                    touch_index = fill_index_q;
                    rdata       = word_sel(sram_rdata, word);
                    ready       = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_WRITE: begin
                sram_w_en = 1'b1;
                if (sram_ready) begin
                    ready   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_d;
    end

    // Fill target is captured on the miss edge so the line lands in the
    // right slot even if the pipeline drops the request mid-fill.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE) begin
            fill_index_q <= index;
            fill_tag_q   <= tag;
            fill_way_q   <= lk.lru_way;
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench: directed vector table, reset-abort sequence and a
// randomized load/store mix against a memory + cache-state reference model.
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] address = '0, wdata = '0;
    logic        mem_r_en = 1'b0, mem_w_en = 1'b0;
    logic [31:0] rdata, sram_address, sram_wdata;
    logic        ready, sram_r_en, sram_w_en;
    logic [63:0] sram_rdata = '0;
    logic        sram_ready = 1'b0;

    always #5 clk = ~clk;

    cache_controller dut (
        .clk          (clk),
        .rst          (rst),
        .address      (address),
        .wdata        (wdata),
        .mem_r_en     (mem_r_en),
        .mem_w_en     (mem_w_en),
        .rdata        (rdata),
        .ready        (ready),
        .sram_address (sram_address),
        .sram_wdata   (sram_wdata),
        .sram_r_en    (sram_r_en),
        .sram_w_en    (sram_w_en),
        .sram_rdata   (sram_rdata),
        .sram_ready   (sram_ready)
    );

    int checks = 0;
    int failures = 0;
    int sram_lat = 1;
    int sram_cnt = 0;
    bit both_seen = 1'b0;

    logic [31:0] mem [logic [31:0]];

    // Reference cache state: per set two {valid, tag} slots and the victim slot.
    bit          rv [64][2];
    logic [9:0]  rt [64][2];
    bit          rl [64];

    typedef struct {
        bit          r;
        bit          w;
        logic [31:0] addr;
        logic [31:0] wd;
        int          lat;
        int          exp_rc;
        int          exp_wc;
        logic [31:0] exp_rd;
        bit          chk_rd;
    } vec_t;

    vec_t vecs [14];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (mem.exists(wa)) return mem[wa];
        return {wa[15:0], ~wa[15:0]};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // One clock cycle: drive at negedge, run the SRAM model, sample before posedge.
    task automatic tick(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input bit rs, output logic rdy, output logic [31:0] rd,
                        output logic ren, output logic wen);
        logic [31:0] la;
        @(negedge clk);
        sram_ready = 1'b0;
        rst = rs; mem_r_en = r; mem_w_en = w; address = a; wdata = d;
        #1;
        ren = sram_r_en; wen = sram_w_en;
        if (ren && wen) both_seen = 1'b1;
        if (rs) begin
            sram_cnt = 0;
        end else if (ren || wen) begin
            sram_cnt++;
            if (sram_cnt >= sram_lat) begin
                sram_cnt   = 0;
                sram_ready = 1'b1;
                la = {sram_address[31:3], 3'b000};
                sram_rdata = {mem_rd(la + 32'd4), mem_rd(la)};
                if (wen) mem[{sram_address[31:2], 2'b00}] = sram_wdata;
            end
        end
        #1;
        rdy = ready; rd = rdata;
    endtask

    task automatic do_req(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input int lat, output int rc, output int wc,
                          output logic [31:0] data, output bit tmo);
        logic rdy, ren, wen;
        logic [31:0] rd;
        sram_lat = lat; rc = 0; wc = 0; tmo = 1'b1; data = '0;
        for (int i = 0; i < 200; i++) begin
            tick(r, w, a, d, 1'b0, rdy, rd, ren, wen);
            rc += int'(ren);
            wc += int'(wen);
            if (rdy) begin
                data = rd; tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic ref_clear();
        for (int s = 0; s < 64; s++) begin
            rv[s][0] = 1'b0; rv[s][1] = 1'b0; rl[s] = 1'b0;
        end
    endtask

    task automatic ref_access(input bit isw, input logic [31:0] a, output bit hit);
        int s, h, v;
        logic [9:0] t;
        s = int'(a[8:3]); t = a[18:9]; hit = 1'b0; h = 0;
        for (int wy = 0; wy < 2; wy++)
            if (rv[s][wy] && rt[s][wy] == t) begin hit = 1'b1; h = wy; end
        if (isw) begin
            if (hit) rv[s][h] = 1'b0;
        end else if (hit) begin
            rl[s] = (h == 0);
        end else begin
            v = int'(rl[s]);
            rv[s][v] = 1'b1; rt[s][v] = t; rl[s] = (v == 0);
        end
    endtask

    task automatic do_reset();
        logic rdy, ren, wen;
        logic [31:0] rd;
        tick(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, rdy, rd, ren, wen);
        tick(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, rdy, rd, ren, wen);
        ref_clear();
    endtask

    task automatic txn(input string nm, input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input int lat);
        bit hit, tmo;
        int rc, wc;
        logic [31:0] exp_d, data;
        exp_d = mem_rd(a);
        ref_access(w, a, hit);
        do_req(r, w, a, d, lat, rc, wc, data, tmo);
        check({nm, " timeout"}, 32'(tmo), 32'd0);
        if (w) begin
            check({nm, " store sram_w cycles"}, wc, lat);
            check({nm, " store sram_r cycles"}, rc, 0);
        end else begin
            check({nm, " load fill cycles"}, rc, hit ? 0 : lat);
            check({nm, " load data"}, data, exp_d);
        end
    endtask

    initial begin
        logic rdy, ren, wen;
        logic [31:0] rd, data;
        int rc, wc;
        bit tmo;

        mem[32'h400] = 32'h11;   mem[32'h404] = 32'h22;
        mem[32'h600] = 32'h3300; mem[32'h800] = 32'h4400;

        //           r  w  addr          wdata          lat rc wc exp_rd         chk
        vecs[0]  = '{1, 0, 32'h400, 32'h0,          5, 5, 0, 32'h11,       1};
        vecs[1]  = '{1, 0, 32'h404, 32'h0,          5, 0, 0, 32'h22,       1};
        vecs[2]  = '{1, 0, 32'h600, 32'h0,          2, 2, 0, 32'h3300,     1};
        vecs[3]  = '{1, 0, 32'h400, 32'h0,          2, 0, 0, 32'h11,       1};
        vecs[4]  = '{1, 0, 32'h800, 32'h0,          3, 3, 0, 32'h4400,     1};
        vecs[5]  = '{1, 0, 32'h400, 32'h0,          3, 0, 0, 32'h11,       1};
        vecs[6]  = '{1, 0, 32'h600, 32'h0,          2, 2, 0, 32'h3300,     1};
        vecs[7]  = '{1, 0, 32'h400, 32'h0,          2, 0, 0, 32'h11,       1};
        vecs[8]  = '{0, 1, 32'h400, 32'hDEADBEEF,   4, 0, 4, 32'h0,        0};
        vecs[9]  = '{1, 0, 32'h400, 32'h0,          3, 3, 0, 32'hDEADBEEF, 1};
        vecs[10] = '{1, 0, 32'h404, 32'h0,          3, 0, 0, 32'h22,       1};
        vecs[11] = '{1, 0, 32'h600, 32'h0,          1, 1, 0, 32'h3300,     1};
        vecs[12] = '{1, 1, 32'h404, 32'h55,         2, 0, 2, 32'h0,        0};
        vecs[13] = '{1, 0, 32'h404, 32'h0,          2, 2, 0, 32'h55,       1};

        do_reset();
        tick(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, rdy, rd, ren, wen);
        check("reset idle ready/r_en/w_en", 32'({rdy, ren, wen}), 32'b100);
        check("reset idle rdata", rd, 32'd0);

        for (int i = 0; i < 14; i++) begin
            do_req(vecs[i].r, vecs[i].w, vecs[i].addr, vecs[i].wd, vecs[i].lat,
                   rc, wc, data, tmo);
            check($sformatf("vec%0d timeout", i), 32'(tmo), 32'd0);
            check($sformatf("vec%0d sram_r cycles", i), rc, vecs[i].exp_rc);
            check($sformatf("vec%0d sram_w cycles", i), wc, vecs[i].exp_wc);
            if (vecs[i].chk_rd)
                check($sformatf("vec%0d rdata", i), data, vecs[i].exp_rd);
        end

        // Reset lands in the third fill cycle of a slow miss.
        sram_lat = 20;
        tick(1'b1, 1'b0, 32'hA08, 32'd0, 1'b0, rdy, rd, ren, wen);
        check("abort miss cycle ready", 32'(rdy), 32'd0);
        tick(1'b1, 1'b0, 32'hA08, 32'd0, 1'b0, rdy, rd, ren, wen);
        check("abort fill1 r_en", 32'(ren), 32'd1);
        tick(1'b1, 1'b0, 32'hA08, 32'd0, 1'b0, rdy, rd, ren, wen);
        tick(1'b1, 1'b0, 32'hA08, 32'd0, 1'b1, rdy, rd, ren, wen);
        tick(1'b0, 1'b0, 32'hA08, 32'd0, 1'b0, rdy, rd, ren, wen);
        check("post-abort idle ready/r_en/w_en", 32'({rdy, ren, wen}), 32'b100);
        check("post-abort rdata", rd, 32'd0);
        do_req(1'b1, 1'b0, 32'h404, 32'd0, 2, rc, wc, data, tmo);
        check("post-abort 0x404 misses", rc, 2);
        check("post-abort 0x404 data", data, 32'h55);
        do_req(1'b1, 1'b0, 32'h600, 32'd0, 2, rc, wc, data, tmo);
        check("post-abort 0x600 misses", rc, 2);
        do_req(1'b1, 1'b0, 32'hA08, 32'd0, 2, rc, wc, data, tmo);
        check("aborted line not installed", rc, 2);

        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic [9:0]  t;
            logic [5:0]  s;
            logic        ws;
            logic [31:0] a;
            int          op, lat;
            t   = 10'($urandom_range(0, 3));
            s   = 6'($urandom_range(0, 3));
            ws  = 1'($urandom_range(0, 1));
            a   = {13'd0, t, s, ws, 2'b00};
            op  = $urandom_range(0, 9);
            lat = $urandom_range(1, 4);
            if (op < 3)
                txn($sformatf("rnd%0d st", n), 1'b0, 1'b1, a, $urandom, lat);
            else if (op == 3)
                txn($sformatf("rnd%0d rw", n), 1'b1, 1'b1, a, $urandom, lat);
            else
                txn($sformatf("rnd%0d ld", n), 1'b1, 1'b0, a, 32'd0, lat);
            if ($urandom_range(0, 3) == 0) begin
                tick(1'b0, 1'b0, a, 32'd0, 1'b0, rdy, rd, ren, wen);
                check($sformatf("rnd%0d idle", n), 32'({rdy, ren, wen}), 32'b100);
            end
        end

        check("sram_r_en and sram_w_en never together", 32'(both_seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
